pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Sequences the 5-stage pipeline around the EX-stage forwarding unit.
- Detects load-use hazards that forwarding cannot resolve and inserts a one-cycle bubble.
- Squashes wrong-path instructions on a taken branch.
- Freezes the whole pipeline while data memory is not ready, releasing it after a bounded timeout.
- Provides saturating stall and flush event counters for performance debug.

Parameters:
- MEM_TIMEOUT, 15: maximum number of frozen cycles for one data-memory access before forced release; legal range 1..2^WAIT_W-1.
- WAIT_W, 4: width of the internal wait counter.
- CNT_W, 16: width of Stall_Cnt and Flush_Cnt.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-low
- Id_Rs  in  5  rs field of the instruction in ID
- Id_Rt  in  5  rt field of the instruction in ID
- Id_UsesRt  in  1  ID instruction reads rt as a source (R-type, sw, beq)
- Ex_Rt  in  5  rt (load destination) of the instruction in EX
- Ex_MemRead  in  1  instruction in EX is a load
- Branch_Taken  in  1  branch resolved taken this cycle
- Mem_Req  in  1  instruction in MEM accesses data memory
- Mem_Ready  in  1  data memory completes the access this cycle
- PC_Write  out  1  PC update enable
- IfId_Write  out  1  IF/ID register enable
- IfId_Flush  out  1  clear IF/ID to a NOP
- IdEx_Write  out  1  ID/EX register enable
- IdEx_Flush  out  1  load a bubble into ID/EX (control bits zeroed)
- ExMem_Write  out  1  EX/MEM register enable
- MemWb_Flush  out  1  load a bubble into MEM/WB
- Mem_Error  out  1  one-cycle pulse on memory timeout
- Wait_State  out  1  1 while the FSM is in MEM_WAIT
- Stall_Cnt  out  CNT_W  number of cycles with PC_Write=0
- Flush_Cnt  out  CNT_W  number of cycles with IfId_Flush=1

Behaviour:
- FSM states: RUN and MEM_WAIT. The state register, wait_cnt and both counters are registered on clk_i. All other outputs are combinational from state and inputs.
- Reset: while rst_i=0, outputs are forced as follows, and on the next edge state becomes RUN and wait_cnt, Stall_Cnt and Flush_Cnt become 0.
  - PC_Write, IfId_Write, IdEx_Write, ExMem_Write = 0
  - IfId_Flush, IdEx_Flush, MemWb_Flush = 1
  - Mem_Error, Wait_State = 0
  - A reset asserted during MEM_WAIT aborts the wait with no Mem_Error.
- Default (RUN, no event): all write enables = 1, all flushes = 0.
- Priority in RUN, highest first: memory miss > taken branch > load-use.
- Memory miss: in RUN with Mem_Req=1 and Mem_Ready=0:
  - PC_Write, IfId_Write, IdEx_Write, ExMem_Write = 0; MemWb_Flush = 1; no other flush.
  - Next state MEM_WAIT; wait_cnt <- 1.
- MEM_WAIT with Mem_Ready=0 and wait_cnt != MEM_TIMEOUT: same freeze as a memory miss; wait_cnt++; Branch_Taken and load-use are ignored.
- MEM_WAIT with Mem_Ready=1: release cycle. Outputs are evaluated exactly as in RUN (branch and load-use rules apply); next state RUN.
- MEM_WAIT with Mem_Ready=0 and wait_cnt == MEM_TIMEOUT: Mem_Error=1; outputs as in RUN; next state RUN.
- Frozen-cycle count: one access freezes at most MEM_TIMEOUT cycles, including the entry cycle.
- Taken branch: IfId_Flush=1, IdEx_Flush=1, PC_Write=1, all write enables 1. A load-use hazard in the same cycle is ignored because the ID instruction is squashed.
- Load-use hazard: fires when Ex_MemRead=1, Ex_Rt!=0, and either Ex_Rt==Id_Rs, or Ex_Rt==Id_Rt with Id_UsesRt=1.
  - Response: PC_Write=0, IfId_Write=0, IdEx_Flush=1; other enables stay 1.
  - Exactly one bubble: next cycle the load has moved to MEM and the hazard term clears.
- Wait_State = (state == MEM_WAIT).
- Counters:
  - Stall_Cnt increments on every non-reset cycle with PC_Write=0 (load-use, miss entry, frozen wait).
  - Flush_Cnt increments on every non-reset cycle with IfId_Flush=1.
  - Both saturate at 2^CNT_W-1 with no wrap.
- Mem_Req=1 with Mem_Ready=1 in RUN: no freeze, zero latency.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles during MEM_WAIT -> outputs at reset values, Mem_Error=0; after release state=RUN, Stall_Cnt=0, all write enables 1.
- Load-use: Ex_MemRead=1, Ex_Rt=8, Id_Rs=8 -> one cycle with PC_Write=0, IfId_Write=0, IdEx_Flush=1; Stall_Cnt=1. Repeat with Ex_Rt=0, or Id_Rt=8 with Id_UsesRt=0 -> no stall.
- Branch over load-use: Branch_Taken=1 with the same hazard present -> IfId_Flush=1, IdEx_Flush=1, PC_Write=1; Flush_Cnt=1, Stall_Cnt unchanged.
- Memory wait: Mem_Req=1, Mem_Ready low for 3 cycles then high -> 3 frozen cycles (ExMem_Write=0, MemWb_Flush=1, Wait_State=1 on cycles 2-3); release on cycle 4; Stall_Cnt=3.
- Timeout: Mem_Ready held 0, MEM_TIMEOUT=15 -> 15 frozen cycles; Mem_Error=1 for exactly one cycle on cycle 16 with enables 1; then RUN.
- Branch during wait: Branch_Taken=1 while frozen -> no flush; Branch_Taken=1 in the release cycle -> IfId_Flush=1. Saturation: preload Stall_Cnt via long stalls (CNT_W=4 build) -> holds at 15.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for the 5-stage pipeline: load-use bubbles,
// branch squashing, data-memory freeze with timeout, event counters.
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int WAIT_W      = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       Id_Rs,
  input  logic [4:0]       Id_Rt,
  input  logic             Id_UsesRt,
  input  logic [4:0]       Ex_Rt,
  input  logic             Ex_MemRead,
  input  logic             Branch_Taken,
  input  logic             Mem_Req,
  input  logic             Mem_Ready,
  output logic             PC_Write,
  output logic             IfId_Write,
  output logic             IfId_Flush,
  output logic             IdEx_Write,
  output logic             IdEx_Flush,
  output logic             ExMem_Write,
  output logic             MemWb_Flush,
  output logic             Mem_Error,
  output logic             Wait_State,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [CNT_W-1:0] Flush_Cnt
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  logic [0:0]        state;
  logic [0:0]        stateNxt;
  logic [WAIT_W-1:0] waitCnt;
  logic [WAIT_W-1:0] waitNxt;
  logic              inWait;
  logic              loadUse;
  logic              missEntry;
  logic              waitHold;
  logic              timeout;

  assign inWait  = (state == MEM_WAIT);
  assign loadUse = Ex_MemRead && (Ex_Rt != 5'd0) &&
                   ((Ex_Rt == Id_Rs) ||
                    (Id_UsesRt && (Ex_Rt == Id_Rt)));
  assign missEntry = !inWait && Mem_Req && !Mem_Ready;
  assign timeout   = inWait && !Mem_Ready &&
                     (waitCnt == WAIT_W'(MEM_TIMEOUT));
  assign waitHold  = inWait && !Mem_Ready && !timeout;

  // Release and timeout cycles fall through to the RUN rules.
  always_comb begin
    PC_Write    = 1'b1;
    IfId_Write  = 1'b1;
    IfId_Flush  = 1'b0;
    IdEx_Write  = 1'b1;
    IdEx_Flush  = 1'b0;
    ExMem_Write = 1'b1;
    MemWb_Flush = 1'b0;
    Mem_Error   = 1'b0;
    Wait_State  = 1'b0;
    if (!rst_i) begin
      PC_Write    = 1'b0;
      IfId_Write  = 1'b0;
      IfId_Flush  = 1'b1;
      IdEx_Write  = 1'b0;
      IdEx_Flush  = 1'b1;
      ExMem_Write = 1'b0;
      MemWb_Flush = 1'b1;
    end else begin
      Wait_State = inWait;
      Mem_Error  = timeout;
      if (missEntry || waitHold) begin
        PC_Write    = 1'b0;
        IfId_Write  = 1'b0;
        IdEx_Write  = 1'b0;
        ExMem_Write = 1'b0;
        MemWb_Flush = 1'b1;
      end else if (Branch_Taken) begin
        IfId_Flush = 1'b1;
        IdEx_Flush = 1'b1;
      end else if (loadUse) begin
        PC_Write   = 1'b0;
        IfId_Write = 1'b0;
        IdEx_Flush = 1'b1;
      end
    end
  end

  always_comb begin
    stateNxt = state;
    waitNxt  = waitCnt;
    if (missEntry) begin
      stateNxt = MEM_WAIT;
      waitNxt  = WAIT_W'(1);
    end else if (waitHold) begin
      waitNxt = waitCnt + WAIT_W'(1);
    end else if (inWait) begin
      stateNxt = RUN;
      waitNxt  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= RUN;
      waitCnt   <= '0;
      Stall_Cnt <= '0;
      Flush_Cnt <= '0;
    end else begin
      state   <= stateNxt;
      waitCnt <= waitNxt;
      if (!PC_Write && (Stall_Cnt != '1))
        Stall_Cnt <= Stall_Cnt + CNT_W'(1);
      if (IfId_Flush && (Flush_Cnt != '1))
        Flush_Cnt <= Flush_Cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller; a CNT_W=4 copy
// shares the stimulus to exercise counter saturation.
module tb_pipeline_hazard_controller;

  logic       clk;
  logic       rstN;
  logic [4:0] idRs;
  logic [4:0] idRt;
  logic       idUsesRt;
  logic [4:0] exRt;
  logic       exMemRead;
  logic       brTaken;
  logic       memReq;
  logic       memReady;

  logic pcW, ifIdW, ifIdF, idExW, idExF, exMemW, memWbF, memErr, waitSt;
  logic [15:0] stallCnt, flushCnt;

  logic sPcW, sIfIdW, sIfIdF, sIdExW, sIdExF, sExMemW, sMemWbF;
  logic sMemErr, sWaitSt;
  logic [3:0] sStallCnt, sFlushCnt;

  int nChk  = 0;
  int nPass = 0;
  int nFail = 0;

  // {PC_Write,IfId_Write,IfId_Flush,IdEx_Write,IdEx_Flush,
  //  ExMem_Write,MemWb_Flush,Mem_Error,Wait_State}
  wire [8:0] ov = {pcW, ifIdW, ifIdF, idExW, idExF,
                   exMemW, memWbF, memErr, waitSt};

  localparam logic [8:0] RST  = 9'b001010100;
  localparam logic [8:0] DEF  = 9'b110101000;
  localparam logic [8:0] LU   = 9'b000111000;
  localparam logic [8:0] BR   = 9'b111111000;
  localparam logic [8:0] FRZ  = 9'b000000100;
  localparam logic [8:0] FRZW = 9'b000000101;
  localparam logic [8:0] RELB = 9'b111111001;
  localparam logic [8:0] TMO  = 9'b110101011;

  pipeline_hazard_controller dut (
    .clk_i(clk), .rst_i(rstN),
    .Id_Rs(idRs), .Id_Rt(idRt), .Id_UsesRt(idUsesRt),
    .Ex_Rt(exRt), .Ex_MemRead(exMemRead),
    .Branch_Taken(brTaken), .Mem_Req(memReq), .Mem_Ready(memReady),
    .PC_Write(pcW), .IfId_Write(ifIdW), .IfId_Flush(ifIdF),
    .IdEx_Write(idExW), .IdEx_Flush(idExF),
    .ExMem_Write(exMemW), .MemWb_Flush(memWbF),
    .Mem_Error(memErr), .Wait_State(waitSt),
    .Stall_Cnt(stallCnt), .Flush_Cnt(flushCnt)
  );

  pipeline_hazard_controller #(.CNT_W(4)) dutSmall (
    .clk_i(clk), .rst_i(rstN),
    .Id_Rs(idRs), .Id_Rt(idRt), .Id_UsesRt(idUsesRt),
    .Ex_Rt(exRt), .Ex_MemRead(exMemRead),
    .Branch_Taken(brTaken), .Mem_Req(memReq), .Mem_Ready(memReady),
    .PC_Write(sPcW), .IfId_Write(sIfIdW), .IfId_Flush(sIfIdF),
    .IdEx_Write(sIdExW), .IdEx_Flush(sIdExF),
    .ExMem_Write(sExMemW), .MemWb_Flush(sMemWbF),
    .Mem_Error(sMemErr), .Wait_State(sWaitSt),
    .Stall_Cnt(sStallCnt), .Flush_Cnt(sFlushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nChk++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    idRs = 0; idRt = 0; idUsesRt = 0;
    exRt = 0; exMemRead = 0;
    brTaken = 0; memReq = 0; memReady = 0;
  endtask

  initial begin
    rstN = 1'b0;
    idle();
    cyc(); cyc();
    settle();
    chk("rst_outs", 32'(ov), 32'(RST));
    chk("rst_stall", 32'(stallCnt), 0);
    chk("rst_flush", 32'(flushCnt), 0);

    rstN = 1'b1;
    settle();
    chk("idle", 32'(ov), 32'(DEF));
    cyc();

    // load-use on rs
    exMemRead = 1; exRt = 8; idRs = 8;
    settle();
    chk("lu_rs", 32'(ov), 32'(LU));
    cyc();
    exMemRead = 0;
    settle();
    chk("lu_clear", 32'(ov), 32'(DEF));
    chk("lu_stall1", 32'(stallCnt), 1);

    // rt == 0 never hazards
    exMemRead = 1; exRt = 0; idRs = 0;
    settle();
    chk("lu_r0", 32'(ov), 32'(DEF));
    cyc();

    // rt match without rt use
    exRt = 8; idRs = 3; idRt = 8; idUsesRt = 0;
    settle();
    chk("lu_nouse", 32'(ov), 32'(DEF));
    cyc();
    idUsesRt = 1;
    settle();
    chk("lu_rt", 32'(ov), 32'(LU));
    cyc();
    chk("lu_stall2", 32'(stallCnt), 2);

    // branch wins over load-use
    brTaken = 1;
    settle();
    chk("br_lu", 32'(ov), 32'(BR));
    cyc();
    chk("br_flush", 32'(flushCnt), 1);
    chk("br_stall", 32'(stallCnt), 2);
    idle();

    // memory wait: 3 frozen cycles then release
    memReq = 1; memReady = 0;
    settle();
    chk("miss_c1", 32'(ov), 32'(FRZ));
    cyc();
    brTaken = 1;
    settle();
    chk("miss_c2_br", 32'(ov), 32'(FRZW));
    cyc();
    brTaken = 0;
    settle();
    chk("miss_c3", 32'(ov), 32'(FRZW));
    cyc();
    memReady = 1; brTaken = 1;
    settle();
    chk("rel_br", 32'(ov), 32'(RELB));
    cyc();
    idle();
    settle();
    chk("after_rel", 32'(ov), 32'(DEF));
    chk("miss_stall", 32'(stallCnt), 5);
    chk("miss_flush", 32'(flushCnt), 2);

    // timeout: 15 frozen cycles, error on 16th
    memReq = 1; memReady = 0;
    settle();
    chk("tmo_c1", 32'(ov), 32'(FRZ));
    cyc();
    for (int i = 2; i <= 15; i++) begin
      chk($sformatf("tmo_c%0d", i), 32'(ov), 32'(FRZW));
      cyc();
    end
    chk("tmo_err", 32'(ov), 32'(TMO));
    cyc();
    memReq = 0;
    settle();
    chk("tmo_after", 32'(ov), 32'(DEF));
    chk("tmo_stall", 32'(stallCnt), 20);
    cyc();

    // hit in RUN costs nothing
    memReq = 1; memReady = 1;
    settle();
    chk("hit", 32'(ov), 32'(DEF));
    cyc();
    chk("hit_next", 32'(ov), 32'(DEF));
    chk("hit_stall", 32'(stallCnt), 20);

    // reset aborts a wait
    memReady = 0;
    cyc();
    chk("rw_wait", 32'(ov), 32'(FRZW));
    chk("rw_stall", 32'(stallCnt), 21);
    rstN = 0;
    settle();
    chk("rw_rst1", 32'(ov), 32'(RST));
    cyc();
    chk("rw_rst2", 32'(ov), 32'(RST));
    cyc();
    rstN = 1;
    idle();
    settle();
    chk("rw_run", 32'(ov), 32'(DEF));
    chk("rw_stall0", 32'(stallCnt), 0);
    chk("rw_flush0", 32'(flushCnt), 0);

    // saturation: 20 load-use stalls, then 20 branches
    exMemRead = 1; exRt = 5; idRs = 5;
    repeat (20) cyc();
    chk("sat_stall16", 32'(stallCnt), 20);
    chk("sat_stall4", 32'(sStallCnt), 15);
    brTaken = 1;
    repeat (20) cyc();
    chk("sat_flush16", 32'(flushCnt), 20);
    chk("sat_flush4", 32'(sFlushCnt), 15);
    chk("sat_hold4", 32'(sStallCnt), 15);
    idle();

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
